apb_master_ctrl: RTL and testbench
==================================

APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 SHALL have parameters, one per line as name, default, meaning:
  ADDR_WIDTH, 32, address width
  DATA_WIDTH, 32, data width (fixed 32; PSTRB 4 bits)
  NUM_SLAVES, 4, number of PSEL outputs
  SLV_BASE, 32'h0000_0000, base of slave 0 window
  SLV_SIZE, 32'h0000_1000, window size per slave (slave i = SLV_BASE + i*SLV_SIZE .. +SLV_SIZE-1)
  TIMEOUT, 16, max ACCESS cycles before abort
REQ-002 SHALL have ports, one per line as name, direction, width, meaning:
  PCLK  in  1  clock, rising edge
  PRESET  in  1  asynchronous reset, active-high
  req_valid  in  1  request valid
  req_ready  out  1  request accepted when high with req_valid
  req_write  in  1  1=write, 0=read
  req_addr  in  ADDR_WIDTH  byte address
  req_wdata  in  32  write data
  req_strb  in  4  write byte strobes
  req_prot  in  3  protection attributes
  rsp_valid  out  1  response valid
  rsp_ready  in  1  response consumed
  rsp_rdata  out  32  read data (0 for writes and errors)
  rsp_err  out  1  slave error, decode error or timeout
  PSEL  out  NUM_SLAVES  one-hot slave select
  PENABLE  out  1  access phase
  PWRITE  out  1  direction
  PADDR  out  ADDR_WIDTH  address
  PWDATA  out  32  write data
  PSTRB  out  4  strobes
  PPROT  out  3  protection
  PRDATA  in  NUM_SLAVES*32  per-slave read data, slave i at [32*i+31:32*i]
  PREADY  in  NUM_SLAVES  per-slave ready
  PSLVERR  in  NUM_SLAVES  per-slave error

Function
REQ-003 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; all outputs registered.
REQ-004 req_ready SHALL be 1 only in IDLE; request accepted on the PCLK edge where req_valid && req_ready.
REQ-005 On acceptance, SHALL latch write, addr, wdata, strb, prot and decode slave index = (req_addr - SLV_BASE) / SLV_SIZE.
REQ-006 Address below SLV_BASE or at/above SLV_BASE + NUM_SLAVES*SLV_SIZE SHALL be a decode error: no PSEL asserted, go IDLE->RESP directly, rsp_err=1, rsp_rdata=0.
REQ-007 Valid decode SHALL go IDLE->SETUP: exactly one PSEL bit=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB/PPROT driven from latched values.
REQ-008 SETUP SHALL last exactly one cycle, then ACCESS with PENABLE=1; all APB outputs held stable through ACCESS.
REQ-009 Reads SHALL drive PSTRB=4'b0000 regardless of req_strb; writes drive latched req_strb; PWDATA=0 on reads.
REQ-010 In ACCESS, on edge where PREADY[sel]=1: capture PRDATA[sel] (reads) and PSLVERR[sel] into rsp_rdata/rsp_err, drop PSEL and PENABLE, go RESP.
REQ-011 Only PREADY/PSLVERR/PRDATA of the selected slave SHALL be observed; others ignored.
REQ-012 ACCESS cycle counter SHALL start at 1 on first ACCESS cycle; if PREADY[sel]=0 in the TIMEOUT-th cycle, abort: drop PSEL/PENABLE, go RESP, rsp_err=1, rsp_rdata=0.
REQ-013 rsp_err SHALL equal captured PSLVERR; rsp_rdata=0 on writes and on any error.
REQ-014 RESP SHALL assert rsp_valid, hold rsp_rdata/rsp_err stable until rsp_ready=1; on that edge go IDLE, rsp_valid=0.
REQ-015 Minimum latency with PREADY=1 at first ACCESS cycle: accept edge N, SETUP N+1, ACCESS N+2, rsp_valid=1 from N+3.
REQ-016 Back-to-back: next request SHALL NOT be accepted in the same cycle rsp_valid&&rsp_ready; earliest acceptance one cycle later (IDLE).

Reset
REQ-017 PRESET=1 SHALL asynchronously force IDLE, clear counter and latches; outputs: req_ready=1 after release (0 while PRESET=1), rsp_valid=0, rsp_rdata=0, rsp_err=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, PPROT=0.
REQ-018 PRESET during SETUP/ACCESS/RESP SHALL abandon the transfer with no response issued; first cycle after release is IDLE.

Verification
REQ-019 Write 0x0000_3010, wdata 0xDEADBEEF, strb 4'b0101, slave 3 PREADY=1 -> PSEL=4'b1000 in SETUP+ACCESS, PSTRB=0101, rsp_valid at N+3, rsp_err=0.
REQ-020 Read 0x0000_1004, slave 1 PREADY low 3 cycles, PRDATA=0x1234_5678 -> ACCESS 4 cycles, PSTRB=0, rsp_rdata=0x1234_5678.
REQ-021 Read 0x0000_4000 (NUM_SLAVES=4) -> no PSEL, rsp_valid at N+1, rsp_err=1, rsp_rdata=0.
REQ-022 Slave 2 PREADY stuck 0 -> PENABLE high exactly 16 cycles, then rsp_err=1, PSEL=0.
REQ-023 Slave 0 PREADY=1 with PSLVERR=1 on read; rsp_ready held 0 for 5 cycles -> rsp_err=1, rsp_rdata=0, rsp_valid held 5+ cycles, req_ready=0 throughout.
REQ-024 PRESET pulsed during ACCESS -> PSEL/PENABLE=0 immediately (asynchronous), no rsp_valid; next request completes normally.

Source files
------------

// File: rtl/apb_master_ctrl.sv
// APB master controller: turns a single request/response handshake into
// APB3/APB4 transfers on one of NUM_SLAVES address windows. It handles
// address decode, wait states, slave errors and an access-phase timeout.
//
// Handshakes (both sides use the same valid/ready rule):
//   - A beat transfers on a rising PCLK edge where valid && ready are both 1.
//   - Once the producer raises valid, it keeps valid and its payload steady
//     until that edge.
//   - req_ready is high only while the controller is idle.
//   - rsp_valid holds, together with a steady rsp_rdata/rsp_err, until the
//     edge where rsp_ready is sampled high.
module apb_master_ctrl #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_SLAVES = 4,
  parameter logic [31:0] SLV_BASE   = 32'h0000_0000,
  parameter logic [31:0] SLV_SIZE   = 32'h0000_1000,
  parameter int          TIMEOUT    = 16
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  input  logic [DATA_WIDTH-1:0]          req_wdata,
  input  logic [3:0]                     req_strb,
  input  logic [2:0]                     req_prot,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic [NUM_SLAVES-1:0]          PSEL,
  output logic                           PENABLE,
  output logic                           PWRITE,
  output logic [ADDR_WIDTH-1:0]          PADDR,
  output logic [DATA_WIDTH-1:0]          PWDATA,
  output logic [3:0]                     PSTRB,
  output logic [2:0]                     PPROT,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]          PREADY,
  input  logic [NUM_SLAVES-1:0]          PSLVERR,
  output logic [1:0]                     dbg_state
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [63:0] WIN_BYTES = 64'(NUM_SLAVES) * 64'(SLV_SIZE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_n;
  logic             ready_q;
  logic [IDX_W-1:0] sel_q;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;
  logic [63:0]      addr64;
  logic [63:0]      off64;
  logic             sel_ready;
  logic             sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic             timeout_hit;

  // req_ready comes from a flop; it is additionally forced low while reset is asserted.
  assign req_ready = ready_q & ~PRESET;
  assign accept    = (state == IDLE) && req_valid && ready_q;
  assign dbg_state = state;

  // Decode the incoming address into a window hit and a slave index.
  always_comb begin
    addr64  = 64'(req_addr);
    off64   = addr64 - 64'(SLV_BASE);
    dec_hit = (addr64 >= 64'(SLV_BASE)) && (off64 < WIN_BYTES);
    dec_idx = IDX_W'(off64 / 64'(SLV_SIZE));
  end

  // Only the latched slave's ready, error and read data are looked at.
  always_comb begin
    sel_ready   = PREADY[sel_q];
    sel_err     = PSLVERR[sel_q];
    sel_rdata   = PRDATA[sel_q*DATA_WIDTH +: DATA_WIDTH];
    timeout_hit = (cnt == CNT_W'(TIMEOUT));
  end

  // State register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = dec_hit ? SETUP : RESP;
      SETUP:   state_n = ACCESS;
      ACCESS:  if (sel_ready || timeout_hit) state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Registered APB outputs, response outputs, request latches and wait counter.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ready_q   <= 1'b1;
      sel_q     <= '0;
      cnt       <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      PPROT     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      ready_q <= (state_n == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            PWRITE <= req_write;
            PADDR  <= req_addr;
            PWDATA <= req_write ? req_wdata : '0;
            PSTRB  <= req_write ? req_strb : 4'b0000;
            PPROT  <= req_prot;
            sel_q  <= dec_idx;
            if (dec_hit) begin
              PSEL    <= NUM_SLAVES'(1) << dec_idx;
              PENABLE <= 1'b0;
            end else begin
              // Out-of-window address: answer immediately with an error.
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          cnt     <= CNT_W'(1);
        end
        ACCESS: begin
          if (sel_ready) begin
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= sel_err;
            rsp_rdata <= (!PWRITE && !sel_err) ? sel_rdata : '0;
          end else if (timeout_hit) begin
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: directed scenarios plus
// randomized transfers, judged against a transaction-level reference model.
module tb_apb_master_ctrl;

  localparam int          AW   = 32;
  localparam int          NS   = 4;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] SIZE = 32'h0000_1000;
  localparam int          TO   = 16;

  logic            clk;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [AW-1:0]   req_addr;
  logic [31:0]     req_wdata;
  logic [3:0]      req_strb;
  logic [2:0]      req_prot;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;
  logic [NS-1:0]   psel;
  logic            penable;
  logic            pwrite;
  logic [AW-1:0]   paddr;
  logic [31:0]     pwdata;
  logic [3:0]      pstrb;
  logic [2:0]      pprot;
  logic [NS*32-1:0] prdata;
  logic [NS-1:0]   pready;
  logic [NS-1:0]   pslverr;
  logic [1:0]      dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] exp_q[$];

  apb_master_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_SLAVES(NS),
    .SLV_BASE(BASE), .SLV_SIZE(SIZE), .TIMEOUT(TO)
  ) dut (
    .PCLK(clk), .PRESET(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr),
    .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_slaves();
    pready  = NS'($urandom);
    pslverr = NS'($urandom);
    for (int i = 0; i < NS; i++) prdata[i*32 +: 32] = $urandom;
  endtask

  task automatic rand_req_fields();
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_strb  = 4'($urandom);
    req_prot  = 3'($urandom);
  endtask

  // One complete transfer: the slave behaviour is given by wait_c (ready low
  // for that many access cycles), serr and srd; the response is held back
  // for hold cycles before being consumed.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [2:0] prot, input int wait_c,
                         input logic serr, input logic [31:0] srd, input int hold);
    logic        hit;
    int          idx;
    logic [3:0]  exp_psel;
    int          exp_acc;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          k;
    int          acc;
    int          psel_cycles;
    int          lat;
    logic        seen;
    logic [32:0] exp_rsp;

    // Reference model: window decode and outcome from plain arithmetic.
    hit      = (64'(addr) >= 64'(BASE)) && (64'(addr) < 64'(BASE) + 64'(NS) * 64'(SIZE));
    idx      = hit ? int'((addr - BASE) / SIZE) : 0;
    exp_psel = hit ? 4'(1 << idx) : 4'b0000;
    exp_acc  = !hit ? 0 : ((wait_c >= TO) ? TO : wait_c + 1);
    exp_err  = !hit || (wait_c >= TO) || serr;
    exp_rd   = (wr || exp_err) ? 32'h0 : srd;
    exp_lat  = hit ? 2 + exp_acc : 1;
    exp_q.push_back({exp_err, exp_rd});

    @(negedge clk);
    check_eq("req_ready_idle", req_ready, 1);
    req_write = wr; req_addr = addr; req_wdata = wdata; req_strb = strb; req_prot = prot;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    rand_slaves();
    @(negedge clk);
    req_valid = 1'b0;
    rand_req_fields();

    k = 1; acc = 0; psel_cycles = 0; lat = 0; seen = 1'b0;
    while (!seen && k <= 60) begin
      if (psel != '0) begin
        psel_cycles++;
        check_eq("psel", psel, exp_psel);
        check_eq("penable", penable, (psel_cycles > 1));
        check_eq("paddr", paddr, addr);
        check_eq("pwrite", pwrite, wr);
        check_eq("pwdata", pwdata, wr ? wdata : 32'h0);
        check_eq("pstrb", pstrb, wr ? strb : 4'h0);
        check_eq("pprot", pprot, prot);
      end else begin
        check_eq("penable_nosel", penable, 0);
      end
      if (rsp_valid) begin
        seen = 1'b1;
        lat  = k;
      end else begin
        if (penable) acc++;
        rand_slaves();
        if (hit && penable) begin
          pready[idx] = (acc == wait_c + 1);
          if (acc == wait_c + 1) begin
            pslverr[idx]        = serr;
            prdata[idx*32 +: 32] = srd;
          end
        end
        @(negedge clk);
        k++;
      end
    end

    exp_rsp = exp_q.pop_front();
    check_eq("rsp_seen", seen, 1);
    check_eq("latency", lat, exp_lat);
    check_eq("access_cycles", acc, exp_acc);
    check_eq("psel_cycles", psel_cycles, hit ? exp_acc + 1 : 0);
    check_eq("rsp", {rsp_err, rsp_rdata}, exp_rsp);

    for (int h = 0; h < hold; h++) begin
      rand_slaves();
      @(negedge clk);
      check_eq("rsp_hold_valid", rsp_valid, 1);
      check_eq("rsp_hold_data", {rsp_err, rsp_rdata}, exp_rsp);
      check_eq("req_ready_resp", req_ready, 0);
    end

    // Consume the response while presenting a new request: it must not be taken.
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h0000_2000;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check_eq("rsp_done_valid", rsp_valid, 0);
    check_eq("b2b_not_taken", psel, 0);
    check_eq("req_ready_after", req_ready, 1);
  endtask

  // Reset during the access phase of a stalled transfer to slave 2.
  task automatic reset_mid_access();
    int acc;
    int seen_rsp;
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h0000_2040; req_wdata = $urandom;
    req_strb = 4'hF; req_prot = 3'b001; req_valid = 1'b1;
    rand_slaves();
    @(negedge clk);
    req_valid = 1'b0;
    acc = 0;
    for (int c = 0; c < 10 && acc < 3; c++) begin
      if (penable) acc++;
      rand_slaves();
      pready[2] = 1'b0;
      @(negedge clk);
    end
    check_eq("rst_mid_in_access", penable, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async_psel", psel, 0);
    check_eq("rst_async_penable", penable, 0);
    check_eq("rst_async_req_ready", req_ready, 0);
    check_eq("rst_async_paddr", paddr, 0);
    @(negedge clk);
    rst = 1'b0;
    seen_rsp = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp++;
    end
    check_eq("rst_no_rsp", seen_rsp, 0);
    check_eq("rst_req_ready", req_ready, 1);
  endtask

  initial begin
    int r;
    int sl;
    logic [31:0] a;
    rst = 1'b1;
    req_valid = 1'b0; rsp_ready = 1'b0;
    req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0; req_prot = '0;
    pready = '0; pslverr = '0; prdata = '0;

    // Reset values.
    #3;
    check_eq("reset_req_ready", req_ready, 0);
    check_eq("reset_rsp_valid", rsp_valid, 0);
    check_eq("reset_rsp", {rsp_err, rsp_rdata}, 0);
    check_eq("reset_psel", psel, 0);
    check_eq("reset_penable", penable, 0);
    check_eq("reset_apb", {pwrite, paddr, pwdata, pstrb, pprot}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("release_req_ready", req_ready, 1);

    // Directed scenarios.
    run_txn(1'b1, 32'h0000_3010, 32'hDEAD_BEEF, 4'b0101, 3'b010, 0, 1'b0, $urandom, 0);
    run_txn(1'b0, 32'h0000_1004, $urandom, 4'b1111, 3'b000, 3, 1'b0, 32'h1234_5678, 1);
    run_txn(1'b0, 32'h0000_4000, $urandom, 4'b1111, 3'b000, 0, 1'b0, $urandom, 0);
    run_txn(1'b1, 32'h0000_2100, $urandom, 4'b0011, 3'b100, 40, 1'b0, $urandom, 0);
    run_txn(1'b0, 32'h0000_0008, $urandom, 4'b1111, 3'b000, 0, 1'b1, 32'hCAFE_F00D, 5);
    run_txn(1'b0, 32'h0000_2FFC, $urandom, 4'b1010, 3'b011, 15, 1'b0, 32'hA5A5_0F0F, 0);
    run_txn(1'b0, 32'h0000_1FF0, $urandom, 4'b1010, 3'b011, 16, 1'b0, 32'hA5A5_0F0F, 0);
    run_txn(1'b1, 32'h0000_0FFF, 32'h0102_0304, 4'b1000, 3'b111, 1, 1'b1, $urandom, 2);
    run_txn(1'b0, 32'h0000_3FFF, $urandom, 4'b0000, 3'b000, 2, 1'b0, 32'h7777_1111, 0);
    run_txn(1'b1, 32'hFFFF_FFFF, $urandom, 4'b1111, 3'b000, 0, 1'b0, $urandom, 3);

    reset_mid_access();
    run_txn(1'b0, 32'h0000_2040, $urandom, 4'b1111, 3'b001, 1, 1'b0, 32'h0BAD_C0DE, 0);

    // Randomized transfers.
    for (int t = 0; t < 40; t++) begin
      r  = $urandom_range(0, 9);
      sl = $urandom_range(0, NS - 1);
      if (r < 8) a = BASE + 32'(sl) * SIZE + ($urandom & (SIZE - 1));
      else       a = $urandom_range(32'hFFFF_FFFF, 32'h0000_4000);
      run_txn(1'($urandom), a, $urandom, 4'($urandom), 3'($urandom),
              ($urandom_range(0, 4) == 0) ? $urandom_range(13, 20) : $urandom_range(0, 4),
              ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
